id_stage: RTL and testbench

//  Decode-stage front end. It is the consumer of the fetch-to-decode handshake and the producer of br_bus.
//  It latches {inst,pc} from fetch and reads the regfile for rs/rt. It forwards operands from EX, MEM and WB.
//  It resolves branches and jumps in decode (MIPS, one delay slot) and passes {pc,inst,rs_val,rt_val} to EX.

---
 rtl/id_stage_pkg.sv | 56 +++++
 rtl/id_fwd_mux.sv | 35 +++
 rtl/id_stage.sv | 134 +++++++++++++
 tb/tb_id_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared bus widths, MIPS opcode/funct constants and branch-class decode
package id_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int DS_TO_ES_BUS_WD = 128;
    localparam int BR_BUS_WD       = 34;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    // j/jal share one class, as do jr/jalr: they differ only in the link write done in EX
    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_BLTZ, BR_BGTZ, BR_BLEZ, BR_J, BR_JR
    } br_kind_e;

    function automatic br_kind_e decode_branch(input logic [31:0] inst);
        br_kind_e kind;
        kind = BR_NONE;
        case (inst[31:26])
            OP_BEQ:       kind = BR_BEQ;
            OP_BNE:       kind = BR_BNE;
            OP_BLEZ:      kind = BR_BLEZ;
            OP_BGTZ:      kind = BR_BGTZ;
            OP_J, OP_JAL: kind = BR_J;
            OP_REGIMM: begin
                if (inst[20:16] == RT_BGEZ)      kind = BR_BGEZ;
                else if (inst[20:16] == RT_BLTZ) kind = BR_BLTZ;
            end
            OP_SPECIAL: begin
                if (inst[5:0] == FN_JR || inst[5:0] == FN_JALR) kind = BR_JR;
            end
            default: kind = BR_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - one operand's ES > MS > WS > regfile forward select with EX-match flag
module id_fwd_mux
    import id_stage_pkg::*;
(
    input  logic [4:0]  raddr_i,
    input  logic [31:0] rf_rdata_i,
    input  logic        es_fwd_valid_i,
    input  logic [4:0]  es_dest_i,
    input  logic [31:0] es_result_i,
    input  logic        ms_fwd_valid_i,
    input  logic [4:0]  ms_dest_i,
    input  logic [31:0] ms_result_i,
    input  logic        ws_fwd_valid_i,
    input  logic [4:0]  ws_dest_i,
    input  logic [31:0] ws_result_i,
    output logic [31:0] val_o,
    output logic        es_hit_o
);

    logic ms_hit;
    logic ws_hit;

    // $0 never matches a producer and always reads as zero, whatever the regfile returns
    always_comb begin
        es_hit_o = es_fwd_valid_i && (es_dest_i == raddr_i) && (raddr_i != 5'd0);
        ms_hit   = ms_fwd_valid_i && (ms_dest_i == raddr_i) && (raddr_i != 5'd0);
        ws_hit   = ws_fwd_valid_i && (ws_dest_i == raddr_i) && (raddr_i != 5'd0);
        if (raddr_i == 5'd0) val_o = 32'h0;
        else if (es_hit_o)   val_o = es_result_i;
        else if (ms_hit)     val_o = ms_result_i;
        else if (ws_hit)     val_o = ws_result_i;
        else                 val_o = rf_rdata_i;
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: operand fetch/forwarding, load-use stall, branch resolution
module id_stage
    import id_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_allowin,
    output logic                       ds_allowin,
    input  logic                       fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic [BR_BUS_WD-1:0]       br_bus,
    output logic [4:0]                 rf_raddr1,
    output logic [4:0]                 rf_raddr2,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    input  logic                       es_fwd_valid,
    input  logic [4:0]                 es_dest,
    input  logic [31:0]                es_result,
    input  logic                       es_is_load,
    input  logic                       ms_fwd_valid,
    input  logic [4:0]                 ms_dest,
    input  logic [31:0]                ms_result,
    input  logic                       ws_fwd_valid,
    input  logic [4:0]                 ws_dest,
    input  logic [31:0]                ws_result
);

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_inst_q, ds_inst_d;
    logic [31:0] ds_pc_q, ds_pc_d;

    logic [31:0] rs_val, rt_val;
    logic        rs_es_hit, rt_es_hit;
    logic        uses_rs, uses_rt;
    logic        load_hazard, ds_ready_go;
    br_kind_e    br_kind;
    logic        is_branch, cond_true, br_stall, br_taken;
    logic [31:0] pc_plus4, br_target;

    logic [5:0]  opcode, funct;
    logic [15:0] imm;

    assign opcode    = ds_inst_q[31:26];
    assign funct     = ds_inst_q[5:0];
    assign imm       = ds_inst_q[15:0];
    assign rf_raddr1 = ds_inst_q[25:21];
    assign rf_raddr2 = ds_inst_q[20:16];

    // accept from fetch whenever DS is empty or its occupant leaves this cycle
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_inst_d  = ds_inst_q;
        ds_pc_d    = ds_pc_q;
        if (ds_allowin) ds_valid_d = fs_to_ds_valid;
        if (ds_allowin && fs_to_ds_valid) {ds_inst_d, ds_pc_d} = fs_to_ds_bus;
    end

    // DS pipeline register; reset empties the stage
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_inst_q  <= 32'h0;
            ds_pc_q    <= 32'h0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_inst_q  <= ds_inst_d;
            ds_pc_q    <= ds_pc_d;
        end
    end

    id_fwd_mux u_rs_fwd (
        .raddr_i(rf_raddr1), .rf_rdata_i(rf_rdata1),
        .es_fwd_valid_i(es_fwd_valid), .es_dest_i(es_dest), .es_result_i(es_result),
        .ms_fwd_valid_i(ms_fwd_valid), .ms_dest_i(ms_dest), .ms_result_i(ms_result),
        .ws_fwd_valid_i(ws_fwd_valid), .ws_dest_i(ws_dest), .ws_result_i(ws_result),
        .val_o(rs_val), .es_hit_o(rs_es_hit)
    );

    id_fwd_mux u_rt_fwd (
        .raddr_i(rf_raddr2), .rf_rdata_i(rf_rdata2),
        .es_fwd_valid_i(es_fwd_valid), .es_dest_i(es_dest), .es_result_i(es_result),
        .ms_fwd_valid_i(ms_fwd_valid), .ms_dest_i(ms_dest), .ms_result_i(ms_result),
        .ws_fwd_valid_i(ws_fwd_valid), .ws_dest_i(ws_dest), .ws_result_i(ws_result),
        .val_o(rt_val), .es_hit_o(rt_es_hit)
    );

    // which source fields are real reads; a field that is really an index, shamt or a dest must not stall
    always_comb begin
        uses_rs = !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI ||
                    (opcode == OP_SPECIAL && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)));
        uses_rt = (opcode == OP_SPECIAL && funct != FN_JR && funct != FN_JALR) ||
                  opcode == OP_BEQ || opcode == OP_BNE ||
                  opcode == OP_SB  || opcode == OP_SH  || opcode == OP_SW;
        load_hazard = ds_valid_q && es_is_load &&
                      ((rs_es_hit && uses_rs) || (rt_es_hit && uses_rt));
        ds_ready_go    = !load_hazard;
        ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
        ds_to_es_valid = ds_valid_q && ds_ready_go;
    end

    // branch condition and target, resolved from forwarded operands
    always_comb begin
        br_kind   = decode_branch(ds_inst_q);
        is_branch = (br_kind != BR_NONE);
        pc_plus4  = ds_pc_q + 32'd4;
        cond_true = 1'b0;
        br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        case (br_kind)
            BR_BEQ:  cond_true = (rs_val == rt_val);
            BR_BNE:  cond_true = (rs_val != rt_val);
            BR_BGEZ: cond_true = !rs_val[31];
            BR_BLTZ: cond_true = rs_val[31];
            BR_BGTZ: cond_true = !rs_val[31] && (rs_val != 32'h0);
            BR_BLEZ: cond_true = rs_val[31] || (rs_val == 32'h0);
            BR_J: begin
                cond_true = 1'b1;
                br_target = {pc_plus4[31:28], ds_inst_q[25:0], 2'b00};
            end
            BR_JR: begin
                cond_true = 1'b1;
                br_target = rs_val;
            end
            default: cond_true = 1'b0;
        endcase
        br_stall = ds_valid_q && is_branch && load_hazard;
        br_taken = ds_valid_q && is_branch && cond_true && !load_hazard;
    end

    assign br_bus       = {br_stall, br_taken, br_taken ? br_target : 32'h0};
    assign ds_to_es_bus = {ds_pc_q, ds_inst_q, rs_val, rt_val};

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - vector table, randomized model comparison and pipeline sequences for id_stage
module tb_id_stage;
    import id_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         es_allowin = 1'b1;
    logic         ds_allowin;
    logic         fs_to_ds_valid = 1'b0;
    logic [63:0]  fs_to_ds_bus = 64'h0;
    logic         ds_to_es_valid;
    logic [127:0] ds_to_es_bus;
    logic [33:0]  br_bus;
    logic [4:0]   rf_raddr1, rf_raddr2;
    logic [31:0]  rf_rdata1, rf_rdata2;
    logic         es_fwd_valid = 1'b0, ms_fwd_valid = 1'b0, ws_fwd_valid = 1'b0, es_is_load = 1'b0;
    logic [4:0]   es_dest = 5'd0, ms_dest = 5'd0, ws_dest = 5'd0;
    logic [31:0]  es_result = 32'h0, ms_result = 32'h0, ws_result = 32'h0;
    logic [31:0]  rf [32];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    id_stage dut (
        .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus), .br_bus(br_bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .es_fwd_valid(es_fwd_valid), .es_dest(es_dest), .es_result(es_result), .es_is_load(es_is_load),
        .ms_fwd_valid(ms_fwd_valid), .ms_dest(ms_dest), .ms_result(ms_result),
        .ws_fwd_valid(ws_fwd_valid), .ws_dest(ws_dest), .ws_result(ws_result)
    );

    typedef struct {
        logic [31:0] inst, pc, rs_rf, rt_rf;
        logic        es_v, es_ld;
        logic [4:0]  es_d;
        logic [31:0] es_r;
        logic        ms_v;
        logic [4:0]  ms_d;
        logic [31:0] ms_r;
        logic        ws_v;
        logic [4:0]  ws_d;
        logic [31:0] ws_r;
        logic        allow;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_stall, exp_taken, exp_hold;
        logic [31:0] exp_target;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fwd();
        es_fwd_valid = 0; es_is_load = 0; ms_fwd_valid = 0; ws_fwd_valid = 0;
        es_dest = 0; ms_dest = 0; ws_dest = 0;
        es_result = 0; ms_result = 0; ws_result = 0;
    endtask

    task automatic do_reset();
        fs_to_ds_valid = 0; idle_fwd(); reset = 1; tick(); reset = 0;
    endtask

    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1; fs_to_ds_bus = {inst, pc}; es_allowin = 1;
        tick();
        fs_to_ds_valid = 0;
    endtask

    // single instruction placed in an empty DS, then observed with the stimulus' forward inputs
    task automatic apply(input stim_t s);
        do_reset();
        load(s.inst, s.pc);
        rf[s.inst[25:21]] = s.rs_rf;
        rf[s.inst[20:16]] = s.rt_rf;
        es_fwd_valid = s.es_v; es_is_load = s.es_ld; es_dest = s.es_d; es_result = s.es_r;
        ms_fwd_valid = s.ms_v; ms_dest = s.ms_d; ms_result = s.ms_r;
        ws_fwd_valid = s.ws_v; ws_dest = s.ws_d; ws_result = s.ws_r;
        es_allowin = s.allow;
        #3;
    endtask

    function automatic logic [31:0] src_val(input logic [4:0] r, input stim_t s);
        if (r == 0) return 32'h0;
        if (s.es_v && s.es_d == r) return s.es_r;
        if (s.ms_v && s.ms_d == r) return s.ms_r;
        if (s.ws_v && s.ws_d == r) return s.ws_r;
        return rf[r];
    endfunction

    task automatic model(input stim_t s, output logic stall, output logic taken, output logic hold,
                         output logic [31:0] target, output logic [31:0] rsv, output logic [31:0] rtv);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt;
        logic        ur, ut, br, cond;
        logic [31:0] p4, tgt;
        op = s.inst[31:26]; fn = s.inst[5:0]; rs = s.inst[25:21]; rt = s.inst[20:16];
        rsv = src_val(rs, s); rtv = src_val(rt, s);
        ur = 1; ut = 0;
        case (op)
            6'h00: begin
                if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin ur = 0; ut = 1; end
                else if (fn == 6'h08 || fn == 6'h09) ut = 0;
                else ut = 1;
            end
            6'h02, 6'h03, 6'h0f: ur = 0;
            6'h04, 6'h05, 6'h28, 6'h29, 6'h2b: ut = 1;
            default: ;
        endcase
        hold = s.es_v && s.es_ld && ((ur && rs != 0 && s.es_d == rs) || (ut && rt != 0 && s.es_d == rt));
        p4 = s.pc + 32'd4;
        tgt = p4 + 32'($signed(s.inst[15:0])) * 32'd4;
        br = 1; cond = 0;
        case (op)
            6'h04: cond = (rsv == rtv);
            6'h05: cond = (rsv != rtv);
            6'h06: cond = ($signed(rsv) <= 0);
            6'h07: cond = ($signed(rsv) > 0);
            6'h01: begin
                if (rt == 0) cond = ($signed(rsv) < 0);
                else if (rt == 1) cond = ($signed(rsv) >= 0);
                else br = 0;
            end
            6'h02, 6'h03: begin cond = 1; tgt = {p4[31:28], s.inst[25:0], 2'b00}; end
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin cond = 1; tgt = rsv; end
                else br = 0;
            end
            default: br = 0;
        endcase
        stall  = br && hold;
        taken  = br && cond && !hold;
        target = taken ? tgt : 32'h0;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        logic [5:0] ops [12] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0f, 6'h09, 6'h23, 6'h2b};
        logic [5:0] fns [5]  = '{6'h08, 6'h09, 6'h00, 6'h21, 6'h23};
        logic [31:0] vals [4];
        vals = '{32'h0, 32'h8000_0000, 32'h7fff_ffff, $urandom};
        s.inst = $urandom;
        s.inst[31:26] = ops[$urandom_range(0, 11)];
        s.inst[25:21] = 5'($urandom_range(0, 7));
        s.inst[20:16] = 5'($urandom_range(0, 7));
        if (s.inst[31:26] == 6'h01) s.inst[20:16] = 5'($urandom_range(0, 2));
        if (s.inst[31:26] == 6'h00) s.inst[5:0] = fns[$urandom_range(0, 4)];
        s.pc    = $urandom & 32'hffff_fffc;
        s.rs_rf = $urandom_range(0, 1) ? vals[$urandom_range(0, 3)] : $urandom;
        s.rt_rf = $urandom_range(0, 1) ? s.rs_rf : $urandom;
        s.es_v = 1'($urandom); s.es_ld = 1'($urandom); s.es_d = 5'($urandom_range(0, 7)); s.es_r = $urandom;
        s.ms_v = 1'($urandom); s.ms_d = 5'($urandom_range(0, 7)); s.ms_r = $urandom;
        s.ws_v = 1'($urandom); s.ws_d = 5'($urandom_range(0, 7)); s.ws_r = $urandom;
        s.allow = 1'($urandom);
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        stim_t s;
        logic e_stall, e_taken, e_hold;
        logic [31:0] e_tgt, e_rs, e_rt;

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        #1;

        // reset state held over three edges, then one instruction flows through
        reset = 1;
        repeat (3) tick();
        #3;
        check("rst_to_es_valid", ds_to_es_valid, 0);
        check("rst_br_bus", br_bus, 34'h0);
        check("rst_allowin", ds_allowin, 1);
        #1 reset = 0;
        tick();
        load(32'h0064_2021, 32'hbfc0_0000);
        #3;
        check("first_to_es_valid", ds_to_es_valid, 1);
        check("first_pc", ds_to_es_bus[127:96], 32'hbfc0_0000);

        // table: {inst, pc, rs_rf, rt_rf, es v/ld/d/r, ms v/d/r, ws v/d/r, allow}, stall, taken, hold, target
        vecs[0]  = '{'{32'h1022_0003, 32'hbfc0_0010, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 1, 0, 32'hbfc0_0020};
        vecs[1]  = '{'{32'h1022_0003, 32'hbfc0_0010, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 0, 0, 32'h0};
        vecs[2]  = '{'{32'h03e0_0008, 32'hbfc0_0030, 0, 0, 0, 0, 0, 0, 1, 31, 32'hbfc0_0100, 0, 0, 0, 1}, 0, 1, 0, 32'hbfc0_0100};
        vecs[3]  = '{'{32'h03e0_0008, 32'hbfc0_0030, 0, 0, 1, 0, 31, 4, 1, 31, 32'hbfc0_0100, 0, 0, 0, 1}, 0, 1, 0, 32'h4};
        vecs[4]  = '{'{32'h0800_0040, 32'hbfc0_fffc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 1, 0, 32'hb000_0100};
        vecs[5]  = '{'{32'h04a0_ffff, 32'h0000_1000, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 1, 0, 32'h0000_1000};
        vecs[6]  = '{'{32'h1cc0_0005, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 0, 0, 32'h0};
        vecs[7]  = '{'{32'h18c0_0005, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 1, 0, 32'h0000_0118};
        vecs[8]  = '{'{32'h00e0_f809, 32'h0000_0200, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h0000_0abc, 1}, 0, 1, 0, 32'h0000_0abc};
        vecs[9]  = '{'{32'h1400_0004, 32'h0000_0300, 32'h55, 32'h55, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1}, 0, 0, 0, 32'h0};
        vecs[10] = '{'{32'h0c60_0000, 32'hbfc0_0000, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1}, 0, 1, 0, 32'hb180_0000};
        vecs[11] = '{'{32'h1022_0003, 32'hbfc0_0010, 5, 5, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1}, 1, 0, 1, 32'h0};
        foreach (vecs[i]) begin
            apply(vecs[i].s);
            check($sformatf("vec%0d_br_bus", i), br_bus, {vecs[i].exp_stall, vecs[i].exp_taken, vecs[i].exp_target});
            check($sformatf("vec%0d_allowin", i), ds_allowin, !vecs[i].exp_hold);
            check($sformatf("vec%0d_to_es_valid", i), ds_to_es_valid, !vecs[i].exp_hold);
        end

        // non-branch load-use stall, and a shift whose rs field is not a real source
        s = '{32'h0064_2021, 32'h40, 1, 2, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1};
        apply(s);
        check("addu_hazard_br_bus", br_bus, 34'h0);
        check("addu_hazard_allowin", ds_allowin, 0);
        s = '{32'h00a2_08c0, 32'h40, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1};
        apply(s);
        check("sll_no_hazard_allowin", ds_allowin, 1);

        // load-use on a bne: one stall cycle, then the value arrives from MS
        do_reset();
        rf[3] = 32'h0;
        load(32'h1460_0004, 32'hbfc0_0020);
        es_fwd_valid = 1; es_is_load = 1; es_dest = 3; es_result = 32'hdead_beef;
        fs_to_ds_valid = 1; fs_to_ds_bus = {32'h0064_2021, 32'hbfc0_0024};
        #3;
        check("lu_br_stall", br_bus[33:32], 2'b10);
        check("lu_allowin", ds_allowin, 0);
        check("lu_to_es_valid", ds_to_es_valid, 0);
        tick();
        es_fwd_valid = 0; es_is_load = 0; ms_fwd_valid = 1; ms_dest = 3; ms_result = 32'h7;
        #3;
        check("lu_fwd_br_bus", br_bus, {2'b01, 32'hbfc0_0034});
        check("lu_fwd_allowin", ds_allowin, 1);
        check("lu_held_pc", ds_to_es_bus[127:96], 32'hbfc0_0020);
        check("lu_fwd_rs_val", ds_to_es_bus[63:32], 32'h7);
        tick();
        fs_to_ds_valid = 0; idle_fwd();
        #3;
        check("lu_slot_pc", ds_to_es_bus[127:96], 32'hbfc0_0024);

        // taken bgez held four cycles by EX back-pressure, then issue with delay slot capture
        do_reset();
        rf[4] = 32'h0;
        load(32'h0481_0008, 32'hbfc0_0040);
        es_allowin = 0;
        fs_to_ds_valid = 1; fs_to_ds_bus = {32'h00a2_08c0, 32'hbfc0_0044};
        for (int c = 0; c < 4; c++) begin
            #3;
            check($sformatf("hold%0d_br_bus", c), br_bus, {2'b01, 32'hbfc0_0064});
            check($sformatf("hold%0d_allowin", c), ds_allowin, 0);
            check($sformatf("hold%0d_inst", c), ds_to_es_bus[127:64], {32'hbfc0_0040, 32'h0481_0008});
            tick();
        end
        es_allowin = 1;
        #3;
        check("release_allowin", ds_allowin, 1);
        tick();
        fs_to_ds_valid = 0;
        #3;
        check("slot_bus", ds_to_es_bus[127:64], {32'hbfc0_0044, 32'h00a2_08c0});
        check("slot_br_bus", br_bus, 34'h0);

        // back-to-back stream: one instruction per cycle
        do_reset();
        es_allowin = 1;
        for (int k = 0; k < 6; k++) begin
            fs_to_ds_valid = 1; fs_to_ds_bus = {32'h0064_2021, 32'h1000 + 32'(k * 4)};
            tick();
            #3;
            check($sformatf("stream%0d_valid", k), ds_to_es_valid, 1);
            check($sformatf("stream%0d_pc", k), ds_to_es_bus[127:96], 32'h1000 + 32'(k * 4));
        end
        fs_to_ds_valid = 0;

        // reset in the middle of a load-use stall
        do_reset();
        load(32'h1460_0004, 32'hbfc0_0020);
        es_fwd_valid = 1; es_is_load = 1; es_dest = 3;
        tick();
        reset = 1;
        tick();
        reset = 0;
        #3;
        check("midrst_to_es_valid", ds_to_es_valid, 0);
        check("midrst_br_bus", br_bus, 34'h0);
        check("midrst_allowin", ds_allowin, 1);
        idle_fwd();

        // randomized instructions against the reference model
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            s = rand_stim();
            apply(s);
            model(s, e_stall, e_taken, e_hold, e_tgt, e_rs, e_rt);
            check($sformatf("rnd%0d_br_bus", n), br_bus, {e_stall, e_taken, e_tgt});
            check($sformatf("rnd%0d_allowin", n), ds_allowin, !e_hold && s.allow);
            check($sformatf("rnd%0d_to_es_valid", n), ds_to_es_valid, !e_hold);
            if (!e_hold)
                check($sformatf("rnd%0d_es_bus", n), ds_to_es_bus, {s.pc, s.inst, e_rs, e_rt});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
